// File: rtl/cgra_pkt_arb_if.sv
// Handshake bundle between two packet requesters, the arbiter and the multi-CGRA input port.
// The slave modport is the arbiter side; the master modport is the requester/sink side.
interface cgra_pkt_arb_if #(
  parameter int PKT_W = 185,
  parameter int CNT_W = 16
);
  logic             req0_val;
  logic             req0_rdy;
  logic [PKT_W-1:0] req0_msg;
  logic             req0_last;
  logic             req1_val;
  logic             req1_rdy;
  logic [PKT_W-1:0] req1_msg;
  logic             req1_last;
  logic             send_val;
  logic             send_rdy;
  logic [PKT_W-1:0] send_msg;
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;
  logic             clr_cnt;
  logic             busy;

  modport slave (
    input  req0_val, req0_msg, req0_last,
    input  req1_val, req1_msg, req1_last,
    input  send_rdy, clr_cnt,
    output req0_rdy, req1_rdy, send_val, send_msg, cnt0, cnt1, busy
  );

  modport master (
    output req0_val, req0_msg, req0_last,
    output req1_val, req1_msg, req1_last,
    output send_rdy, clr_cnt,
    input  req0_rdy, req1_rdy, send_val, send_msg, cnt0, cnt1, busy
  );
endinterface

// File: rtl/cgra_pkt_arb.sv
// Two-requester packet arbiter with burst locking, round-robin priority between bursts,
// a single registered output stage and saturating per-requester accept counters.
module cgra_pkt_arb #(
  parameter int PKT_W = 185,
  parameter int CNT_W = 16
) (
  input  logic          clk,
  input  logic          rstn,
  cgra_pkt_arb_if.slave bus
);
  // state | meaning
  // IDLE  | no burst in progress; grant by valid and prio
  // LOCK0 | req0 burst in progress; only req0 served
  // LOCK1 | req1 burst in progress; only req1 served
  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q;
  logic             prio_q;
  logic             send_val_q;
  logic [PKT_W-1:0] send_msg_q;
  logic [CNT_W-1:0] cnt0_q;
  logic [CNT_W-1:0] cnt1_q;

  logic out_free;
  logic sel1;
  logic rdy0;
  logic rdy1;
  logic acc0;
  logic acc1;

  always_comb begin
    out_free = !send_val_q || bus.send_rdy;
    sel1     = bus.req1_val && (!bus.req0_val || prio_q);
    // rstn gating keeps both ready lines low for the whole reset window
    rdy0     = rstn && out_free &&
               (((state_q == IDLE) && bus.req0_val && !sel1) || (state_q == LOCK0));
    rdy1     = rstn && out_free &&
               (((state_q == IDLE) && sel1) || (state_q == LOCK1));
    acc0     = rdy0 && bus.req0_val;
    acc1     = rdy1 && bus.req1_val;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= IDLE;
      prio_q     <= 1'b0;
      send_val_q <= 1'b0;
      send_msg_q <= '0;
      cnt0_q     <= '0;
      cnt1_q     <= '0;
    end else begin
      if (acc0) begin
        send_val_q <= 1'b1;
        send_msg_q <= bus.req0_msg;
        if (bus.req0_last) begin
          state_q <= IDLE;
          prio_q  <= 1'b1;
        end else begin
          state_q <= LOCK0;
        end
      end else if (acc1) begin
        send_val_q <= 1'b1;
        send_msg_q <= bus.req1_msg;
        if (bus.req1_last) begin
          state_q <= IDLE;
          prio_q  <= 1'b0;
        end else begin
          state_q <= LOCK1;
        end
      end else if (bus.send_rdy) begin
        send_val_q <= 1'b0;
      end

      if (bus.clr_cnt) begin
        cnt0_q <= '0;
        cnt1_q <= '0;
      end else begin
        if (acc0 && (cnt0_q != CNT_MAX)) cnt0_q <= cnt0_q + 1'b1;
        if (acc1 && (cnt1_q != CNT_MAX)) cnt1_q <= cnt1_q + 1'b1;
      end
    end
  end

  assign bus.req0_rdy = rdy0;
  assign bus.req1_rdy = rdy1;
  assign bus.send_val = send_val_q;
  assign bus.send_msg = send_msg_q;
  assign bus.cnt0     = cnt0_q;
  assign bus.cnt1     = cnt1_q;
  assign bus.busy     = (state_q != IDLE) || send_val_q;
endmodule

// File: doc/cgra_pkt_arb.md
CGRA_PKT_ARB -- requirements
Module: cgra_pkt_arb

Interface
REQ-001 SHALL have parameter PKT_W, default 185, width of one CGRA packet (27-bit header + 158-bit payload).
REQ-002 SHALL have parameter CNT_W, default 16, width of each per-requester packet counter.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rstn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have ports req0_val / req1_val  input  1  requester packet valid (req0 = CPU config path, req1 = DMA path).
REQ-006 SHALL have ports req0_rdy / req1_rdy  output  1  requester packet accepted when val and rdy are both high.
REQ-007 SHALL have ports req0_msg / req1_msg  input  PKT_W  requester packet.
REQ-008 SHALL have ports req0_last / req1_last  input  1  marks the final packet of a burst; qualified by val.
REQ-009 SHALL have port send_val  output  1  packet valid toward the multi-CGRA recv_from_cpu_pkt port.
REQ-010 SHALL have port send_rdy  input  1  multi-CGRA ready.
REQ-011 SHALL have port send_msg  output  PKT_W  forwarded packet.
REQ-012 SHALL have ports cnt0 / cnt1  output  CNT_W  packets accepted from req0 / req1.
REQ-013 SHALL have port clr_cnt  input  1  synchronous clear of cnt0 and cnt1.
REQ-014 SHALL have port busy  output  1  high when a burst is locked or the output register holds a packet.

Function
REQ-015 SHALL hold one output register (send_val, send_msg); out_free = !send_val || send_rdy.
REQ-016 SHALL complete an output handshake when send_val && send_rdy; send_val then drops unless a new packet is loaded the same cycle.
REQ-017 SHALL have latency of exactly 1 cycle: a packet accepted in cycle N appears on send_msg with send_val=1 in cycle N+1; full throughput of 1 packet/cycle when send_rdy stays high.
REQ-018 SHALL keep send_msg and send_val stable while send_val=1 and send_rdy=0.
REQ-019 SHALL implement FSM states IDLE, LOCK0, LOCK1 plus a 1-bit priority pointer prio (0 = req0 preferred).
REQ-020 In IDLE, SHALL select combinationally: only reqX valid -> X; both valid -> prio; none -> no grant.
REQ-021 SHALL drive reqX_rdy = out_free && (X is the selected requester in IDLE, or state == LOCKX); the other requester's rdy SHALL be 0.
REQ-022 In IDLE, acceptance with last=0 SHALL go to LOCKX; acceptance with last=1 SHALL stay in IDLE and set prio to the other requester.
REQ-023 In LOCKX, only requester X SHALL be served; acceptance with last=1 SHALL go to IDLE and set prio to the other requester; the other requester SHALL stall regardless of its valid.
REQ-024 In LOCKX, with reqX_val=0, SHALL wait indefinitely; there is no timeout.
REQ-025 SHALL never change state or prio without an accepted packet.
REQ-026 SHALL increment cntX by 1 on each acceptance from X, saturating at 2^CNT_W-1.
REQ-027 clr_cnt=1 SHALL set both counters to 0 on the next edge; clear SHALL win over a simultaneous increment.
REQ-028 busy = (state != IDLE) || send_val.

Reset
REQ-029 When rstn=0 at a rising edge: state=IDLE, prio=0, send_val=0, send_msg=0, cnt0=cnt1=0.
REQ-030 While rstn=0: req0_rdy=req1_rdy=0, busy=0 from the first reset edge.
REQ-031 Reset mid-burst SHALL drop the lock and any packet held in the output register without forwarding it; the first post-reset grant follows REQ-020 with prio=0.

Verification
REQ-032 Single packet: req0_val=1, last=1, msg=0x5A, send_rdy=1 -> req0_rdy=1 same cycle; next cycle send_val=1, send_msg=0x5A; cnt0=1; state IDLE, prio=1.
REQ-033 Contention: both valid every cycle, all last=1, send_rdy=1 -> grants alternate 0,1,0,1; after 8 cycles cnt0=cnt1=4.
REQ-034 Burst lock: req0 sends 3 packets (last on third) while req1_val=1 throughout -> req1_rdy=0 for those 3 cycles; req1 is granted on the 4th cycle.
REQ-035 Backpressure: send_rdy=0 for 5 cycles with a packet held -> send_msg stable, req rdy=0; send_rdy=1 -> drains, then 1 packet/cycle, no loss or duplication.
REQ-036 Counters: CNT_W=4, 17 req1 packets -> cnt1 saturates at 15; clr_cnt asserted together with an accept -> cnt1=0.
REQ-037 Reset mid-burst: rstn=0 in LOCK1 with send_val=1 -> next cycle send_val=0, busy=0, cnt0=cnt1=0; after release both valid -> req0 granted first.
